// File: rtl/skein_sched_pkg.sv
// Shared types and widths for the skein512 nonce scheduler.
package skein_sched_pkg;

    localparam int NONCE_W  = 32;
    localparam int TARGET_W = 64;
    localparam int CNT_W    = NONCE_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // Inclusive range size; a full wrap (last == first-1) gives 2^32.
    function automatic logic [CNT_W-1:0] job_count(input logic [NONCE_W-1:0] first,
                                                   input logic [NONCE_W-1:0] last);
        return {1'b0, last - first} + CNT_W'(1);
    endfunction

endpackage

// File: rtl/skein_nonce_sched_if.sv
// Host job / core / found-FIFO bundle for skein_nonce_sched; the DUT uses the slave modport.
interface skein_nonce_sched_if;
    import skein_sched_pkg::*;

    logic                start;
    logic                abort;
    logic [511:0]        job_midstate;
    logic [95:0]         job_data;
    logic [NONCE_W-1:0]  job_nonce_start;
    logic [NONCE_W-1:0]  job_nonce_end;
    logic [TARGET_W-1:0] job_target;
    logic [511:0]        core_midstate;
    logic [95:0]         core_data;
    logic [NONCE_W-1:0]  core_nonce;
    logic [511:0]        core_hash;
    logic                busy;
    logic                done;
    logic                found_valid;
    logic                found_ready;
    logic [NONCE_W-1:0]  found_nonce;
    logic                found_ovf;

    modport master (
        output start, abort, job_midstate, job_data, job_nonce_start, job_nonce_end,
               job_target, core_hash, found_ready,
        input  core_midstate, core_data, core_nonce, busy, done, found_valid,
               found_nonce, found_ovf
    );

    modport slave (
        input  start, abort, job_midstate, job_data, job_nonce_start, job_nonce_end,
               job_target, core_hash, found_ready,
        output core_midstate, core_data, core_nonce, busy, done, found_valid,
               found_nonce, found_ovf
    );

endinterface

// File: rtl/skein_found_fifo.sv
// Small first-word-fall-through FIFO for hit nonces; pushes into a full FIFO are
// dropped (ovf pulse) unless a pop frees the slot in the same cycle.
module skein_found_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && pop_ready;
    assign push_ok   = push && (!full || pop);
    assign ovf       = push && full && !pop;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/skein_nonce_sched.sv
// Nonce scheduler in front of the skein512 core: one launch per 2-cycle slot, retire
// tracking via an in-flight shift register, hit FIFO. Build macro SKEIN_SCHED_STOP_ON_FIND_EN.
//
// state | meaning
// IDLE  | no job; waits for start
// RUN   | launching nonces on slot cycles, retiring earlier ones
// DRAIN | all launches issued; waiting for in-flight hashes to retire
module skein_nonce_sched
    import skein_sched_pkg::*;
#(
    parameter int HASH_LAT    = 184,
    parameter int PHASE_OFS   = 0,
    parameter int FOUND_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    skein_nonce_sched_if.slave bus
);
    sched_state_e        state;
    sched_state_e        state_nxt;
    logic                slot_tgl;
    logic [HASH_LAT-1:0] inflight;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    launch_cnt;
    logic [CNT_W-1:0]    retire_cnt;
    logic [NONCE_W-1:0]  retire_nonce;
    logic [TARGET_W-1:0] target_q;
    logic                accept;
    logic                launch;
    logic                retire;
    logic                hit;
    logic                stop_hit;
    logic                last_retire;
    logic                fifo_ovf;
    logic                unused_hash;

    assign unused_hash = ^bus.core_hash[511:TARGET_W];

    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign launch = (state == RUN) && (slot_tgl == PHASE_OFS[0]) && !bus.abort;
    assign retire = inflight[HASH_LAT-1] && !bus.abort;
    assign hit    = retire && (bus.core_hash[TARGET_W-1:0] <= target_q);
    // Comparing against launches (not the job size) also covers an early stop.
    assign last_retire = (state == DRAIN) && retire && (retire_cnt + CNT_W'(1) == launch_cnt);

`ifdef SKEIN_SCHED_STOP_ON_FIND_EN
    assign stop_hit = (state == RUN) && hit;
`else
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = (state != IDLE);
        bus.done  = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if ((launch && issue_cnt == CNT_W'(1)) || stop_hit) state_nxt = DRAIN;
            DRAIN: begin
                if (last_retire) begin
                    state_nxt = IDLE;
                    bus.done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_tgl          <= 1'b0;
            inflight          <= '0;
            issue_cnt         <= '0;
            launch_cnt        <= '0;
            retire_cnt        <= '0;
            retire_nonce      <= '0;
            target_q          <= '0;
            bus.core_midstate <= '0;
            bus.core_data     <= '0;
            bus.core_nonce    <= '0;
            bus.found_ovf     <= 1'b0;
        end else begin
            slot_tgl <= ~slot_tgl;
            if (bus.abort) begin
                inflight     <= '0;
                issue_cnt    <= '0;
                launch_cnt   <= '0;
                retire_cnt   <= '0;
                retire_nonce <= '0;
            end else begin
                inflight <= {inflight[HASH_LAT-2:0], launch};
                if (accept) begin
                    bus.core_midstate <= bus.job_midstate;
                    bus.core_data     <= bus.job_data;
                    bus.core_nonce    <= bus.job_nonce_start;
                    retire_nonce      <= bus.job_nonce_start;
                    target_q          <= bus.job_target;
                    issue_cnt         <= job_count(bus.job_nonce_start, bus.job_nonce_end);
                    launch_cnt        <= '0;
                    retire_cnt        <= '0;
                end
                if (launch) begin
                    bus.core_nonce <= bus.core_nonce + NONCE_W'(1);
                    launch_cnt     <= launch_cnt + CNT_W'(1);
                end
                if (stop_hit)    issue_cnt <= '0;
                else if (launch) issue_cnt <= issue_cnt - CNT_W'(1);
                if (retire) begin
                    retire_nonce <= retire_nonce + NONCE_W'(1);
                    retire_cnt   <= retire_cnt + CNT_W'(1);
                end
            end
            if (accept)        bus.found_ovf <= 1'b0;
            else if (fifo_ovf) bus.found_ovf <= 1'b1;
        end
    end

    skein_found_fifo #(
        .W     (NONCE_W),
        .DEPTH (FOUND_DEPTH)
    ) u_found_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hit),
        .push_data (retire_nonce),
        .pop_ready (bus.found_ready),
        .out_valid (bus.found_valid),
        .out_data  (bus.found_nonce),
        .ovf       (fifo_ovf)
    );

endmodule
